// File: rtl/pulse_cmd_parser_pkg.sv
// Shared definitions for the host command parser: command codes, ack codes
// and the frame FSM state encoding.
package pulse_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PAYLOAD = 2'd1,
        COMMIT  = 2'd2
    } state_t;

    localparam logic [7:0] CONT_SET_DELAY  = 8'd0;
    localparam logic [7:0] CONT_SET_PERIOD = 8'd1;
    localparam logic [7:0] CONT_SET_PULSE1 = 8'd2;
    localparam logic [7:0] CONT_SET_PULSE2 = 8'd3;
    localparam logic [7:0] CONT_TOGGLE_P1  = 8'd4;
    localparam logic [7:0] CONT_SET_CPMG   = 8'd5;
    localparam logic [7:0] CONT_SET_ATT    = 8'd6;
    localparam logic [7:0] CONT_SET_NUTW   = 8'd7;
    localparam logic [7:0] CONT_SET_NUTD   = 8'd8;

    localparam logic [7:0] ACK_BADCMD  = 8'hFF;
    localparam logic [7:0] ACK_TIMEOUT = 8'hFE;

    localparam int FRAME_PAYLOAD_BYTES = 4;

    function automatic logic is_valid_cmd(input logic [7:0] cmd);
        return cmd <= CONT_SET_NUTD;
    endfunction

endpackage

// File: rtl/pulse_cmd_parser_if.sv
// Byte streams between the UART and the command parser.
// rx: rx_valid is a one-cycle strobe with no back-pressure. tx: tx_data is
// transferred on every cycle where tx_valid && tx_ready; tx_valid stays high
// until that cycle.
interface pulse_cmd_parser_if;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;

    modport master (
        output rx_data,
        output rx_valid,
        output tx_ready,
        input  tx_data,
        input  tx_valid
    );

    modport slave (
        input  rx_data,
        input  rx_valid,
        input  tx_ready,
        output tx_data,
        output tx_valid
    );
endinterface

// File: rtl/pulse_cmd_parser_ack_holder.sv
// One-entry acknowledge register. A push always wins over a same-cycle
// handshake, so the newest ack is never lost.
module ack_holder
    import pulse_pkg::*;
(
    input  logic       clk,
    input  logic       resetn,
    input  logic       push,
    input  logic [7:0] push_data,
    input  logic       tx_ready,
    output logic [7:0] tx_data,
    output logic       tx_valid
);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            tx_valid <= 1'b0;
            tx_data  <= 8'h00;
        end else if (push) begin
            tx_valid <= 1'b1;
            tx_data  <= push_data;
        end else if (tx_valid && tx_ready) begin
            tx_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/pulse_cmd_parser.sv
// Assembles 5-byte host frames into the pulse-timing register bank, pulses
// upd on every register change and queues one ack byte per frame.
module pulse_cmd_parser
    import pulse_pkg::*;
#(
    parameter int          TIMEOUT    = 50000,
    parameter logic [31:0] DEF_PERIOD = 32'd20000,
    parameter logic [31:0] DEF_PULSE1 = 32'd6,
    parameter logic [31:0] DEF_PULSE2 = 32'd12
) (
    input  logic              clk,
    input  logic              resetn,
    pulse_cmd_parser_if.slave bus,
    output logic [31:0]       delay,
    output logic [31:0]       period,
    output logic [31:0]       pulse1,
    output logic [31:0]       pulse2,
    output logic              pulse1_en,
    output logic [7:0]        cpmg,
    output logic [5:0]        att,
    output logic [31:0]       nut_w,
    output logic [31:0]       nut_d,
    output logic              upd,
    output logic              frame_err,
    output state_t            fsm_state
);

    localparam int               CNT_W   = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT);

    state_t           state_q;
    state_t           state_d;
    logic [7:0]       cmd_q;
    logic [1:0]       idx_q;
    logic [31:0]      payload_q;
    logic [CNT_W-1:0] cnt_q;

    logic       frame_start;
    logic       timeout_hit;
    logic       commit;
    logic       wr_en;
    logic       ferr_d;
    logic       ack_push;
    logic [7:0] ack_data;

    assign fsm_state = state_q;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (bus.rx_valid) state_d = PAYLOAD;
            end
            PAYLOAD: begin
                if (bus.rx_valid && idx_q == 2'(FRAME_PAYLOAD_BYTES - 1)) state_d = COMMIT;
                else if (timeout_hit)                                      state_d = IDLE;
            end
            COMMIT: begin
                // A byte arriving during COMMIT already opens the next frame.
                state_d = bus.rx_valid ? PAYLOAD : IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        frame_start = bus.rx_valid && (state_q != PAYLOAD);
        // A byte in the expiry cycle takes priority over the timeout.
        timeout_hit = (state_q == PAYLOAD) && !bus.rx_valid && (cnt_q == CNT_MAX);
        commit      = (state_q == COMMIT);
        wr_en       = commit && is_valid_cmd(cmd_q);
        ferr_d      = (commit && !is_valid_cmd(cmd_q)) || timeout_hit;
        ack_push    = commit || timeout_hit;
        if (timeout_hit)              ack_data = ACK_TIMEOUT;
        else if (is_valid_cmd(cmd_q)) ack_data = cmd_q;
        else                          ack_data = ACK_BADCMD;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            cmd_q     <= 8'h00;
            idx_q     <= 2'd0;
            payload_q <= 32'h0;
            cnt_q     <= '0;
        end else if (frame_start) begin
            cmd_q <= bus.rx_data;
            idx_q <= 2'd0;
            cnt_q <= '0;
        end else if (state_q == PAYLOAD) begin
            if (bus.rx_valid) begin
                payload_q[{idx_q, 3'b000} +: 8] <= bus.rx_data;
                idx_q                           <= idx_q + 2'd1;
                cnt_q                           <= '0;
            end else if (cnt_q != CNT_MAX) begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            delay     <= 32'h0;
            period    <= DEF_PERIOD;
            pulse1    <= DEF_PULSE1;
            pulse2    <= DEF_PULSE2;
            pulse1_en <= 1'b1;
            cpmg      <= 8'h00;
            att       <= 6'h00;
            nut_w     <= 32'h0;
            nut_d     <= 32'h0;
            upd       <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            upd       <= wr_en;
            frame_err <= ferr_d;
            if (wr_en) begin
                case (cmd_q)
                    CONT_SET_DELAY:  delay     <= payload_q;
                    CONT_SET_PERIOD: period    <= payload_q;
                    CONT_SET_PULSE1: pulse1    <= payload_q;
                    CONT_SET_PULSE2: pulse2    <= payload_q;
                    CONT_TOGGLE_P1:  pulse1_en <= ~pulse1_en;
                    CONT_SET_CPMG:   cpmg      <= payload_q[7:0];
                    CONT_SET_ATT:    att       <= payload_q[5:0];
                    CONT_SET_NUTW:   nut_w     <= payload_q;
                    CONT_SET_NUTD:   nut_d     <= payload_q;
                    default: ;
                endcase
            end
        end
    end

    ack_holder u_ack_holder (
        .clk       (clk),
        .resetn    (resetn),
        .push      (ack_push),
        .push_data (ack_data),
        .tx_ready  (bus.tx_ready),
        .tx_data   (bus.tx_data),
        .tx_valid  (bus.tx_valid)
    );

endmodule

// File: tb/tb_pulse_cmd_parser.sv
// Bench for pulse_cmd_parser: directed scenarios plus random frames checked
// against a register-array model and an ack queue.
module tb_pulse_cmd_parser;
    import pulse_pkg::*;

    localparam int TO = 40;

    logic clk    = 1'b0;
    logic resetn = 1'b1;
    always #5 clk = ~clk;

    pulse_cmd_parser_if bus();

    logic [31:0] delay, period, pulse1, pulse2, nut_w, nut_d;
    logic        pulse1_en, upd, frame_err;
    logic [7:0]  cpmg;
    logic [5:0]  att;
    state_t      fsm_state;

    pulse_cmd_parser #(.TIMEOUT(TO)) dut (
        .clk       (clk),
        .resetn    (resetn),
        .bus       (bus),
        .delay     (delay),
        .period    (period),
        .pulse1    (pulse1),
        .pulse2    (pulse2),
        .pulse1_en (pulse1_en),
        .cpmg      (cpmg),
        .att       (att),
        .nut_w     (nut_w),
        .nut_d     (nut_d),
        .upd       (upd),
        .frame_err (frame_err),
        .fsm_state (fsm_state)
    );

    int total = 0;
    int bad   = 0;
    int upd_cnt = 0, ferr_cnt = 0, exp_upd = 0, exp_ferr = 0;
    logic [31:0] m_reg[9];
    logic [7:0]  exp_q[$];
    logic [7:0]  exp_ack;
    bit          hold_mode = 1'b0;

    // Scoreboard: pulse counters and ack transfers.
    always @(negedge clk) begin
        if (upd) upd_cnt++;
        if (frame_err) ferr_cnt++;
        if (resetn && bus.tx_valid && bus.tx_ready) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL ack_unexpected got=%h", bus.tx_data);
            end else begin
                exp_ack = exp_q.pop_front();
                if (bus.tx_data !== exp_ack) begin
                    bad++;
                    $display("FAIL ack_value got=%h want=%h", bus.tx_data, exp_ack);
                end
            end
        end
    end

    function automatic logic [31:0] act(input int i);
        case (i)
            0: return delay;
            1: return period;
            2: return pulse1;
            3: return pulse2;
            4: return {31'd0, pulse1_en};
            5: return {24'd0, cpmg};
            6: return {26'd0, att};
            7: return nut_w;
            8: return nut_d;
            default: return 32'h0;
        endcase
    endfunction

    task automatic model_reset();
        m_reg[0] = 32'd0;     m_reg[1] = 32'd20000; m_reg[2] = 32'd6;
        m_reg[3] = 32'd12;    m_reg[4] = 32'd1;     m_reg[5] = 32'd0;
        m_reg[6] = 32'd0;     m_reg[7] = 32'd0;     m_reg[8] = 32'd0;
        exp_q.delete();
    endtask

    task automatic push_ack(input logic [7:0] a);
        if (hold_mode && exp_q.size() > 0) exp_q[exp_q.size()-1] = a;
        else exp_q.push_back(a);
    endtask

    task automatic model_frame(input logic [7:0] c, input logic [31:0] p);
        if (c > 8) begin
            exp_ferr++;
            push_ack(ACK_BADCMD);
        end else begin
            exp_upd++;
            if (c == 4)      m_reg[4] = m_reg[4] ^ 32'd1;
            else if (c == 5) m_reg[5] = {24'd0, p[7:0]};
            else if (c == 6) m_reg[6] = {26'd0, p[5:0]};
            else             m_reg[c] = p;
            push_ack(c);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        bus.rx_data  = b;
        bus.rx_valid = 1'b1;
        @(posedge clk); #1;
        bus.rx_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic send_frame(input logic [7:0] c, input logic [31:0] p, input int gap);
        model_frame(c, p);
        send_byte(c);
        for (int i = 0; i < 4; i++) begin
            idle(gap);
            send_byte(p[8*i +: 8]);
        end
    endtask

    task automatic drain(output bit ok);
        for (int i = 0; i < 30 && exp_q.size() != 0; i++) idle(1);
        ok = (exp_q.size() == 0);
    endtask

    task automatic test_reset();
        model_reset();
        resetn = 1'b0;
        idle(3);
        for (int i = 0; i < 9; i++) begin
            total++;
            if (act(i) !== m_reg[i]) begin bad++; $display("FAIL reset_reg%0d got=%h want=%h", i, act(i), m_reg[i]); end
        end
        total++;
        if ({bus.tx_valid, bus.tx_data, upd, frame_err} !== 11'd0) begin
            bad++; $display("FAIL reset_flags got=%b want=0", {bus.tx_valid, bus.tx_data, upd, frame_err});
        end
        total++;
        if (fsm_state !== IDLE) begin bad++; $display("FAIL reset_state got=%0d want=%0d", fsm_state, IDLE); end
        resetn = 1'b1;
        idle(2);
    endtask

    task automatic test_delay();
        bit ok;
        bus.tx_ready = 1'b0;
        send_frame(8'h00, 32'h0000_0064, 0);
        idle(3);
        total++;
        if (delay !== 32'd100) begin bad++; $display("FAIL delay_value got=%0d want=100", delay); end
        total++;
        if (upd_cnt !== exp_upd) begin bad++; $display("FAIL delay_upd got=%0d want=%0d", upd_cnt, exp_upd); end
        total++;
        if (bus.tx_valid !== 1'b1 || bus.tx_data !== 8'h00) begin
            bad++; $display("FAIL delay_ack_pending got=%b/%h want=1/00", bus.tx_valid, bus.tx_data);
        end
        bus.tx_ready = 1'b1;
        drain(ok);
        total++;
        if (!ok) begin bad++; $display("FAIL delay_drain got=%0d want=0 pending", exp_q.size()); end
    endtask

    task automatic test_toggle();
        bit ok;
        for (int k = 0; k < 2; k++) begin
            send_frame(8'h04, 32'h0, 0);
            idle(3);
            total++;
            if (pulse1_en !== m_reg[4][0]) begin bad++; $display("FAIL toggle%0d got=%b want=%b", k, pulse1_en, m_reg[4][0]); end
        end
        total++;
        if (upd_cnt !== exp_upd) begin bad++; $display("FAIL toggle_upd got=%0d want=%0d", upd_cnt, exp_upd); end
        drain(ok);
        total++;
        if (!ok) begin bad++; $display("FAIL toggle_drain got=%0d want=0 pending", exp_q.size()); end
    endtask

    task automatic test_timeout();
        bit ok;
        logic [31:0] p;
        exp_ferr++;
        push_ack(ACK_TIMEOUT);
        send_byte(8'h01); send_byte(8'hAA); send_byte(8'hBB);
        idle(TO + 4);
        total++;
        if (ferr_cnt !== exp_ferr) begin bad++; $display("FAIL timeout_ferr got=%0d want=%0d", ferr_cnt, exp_ferr); end
        total++;
        if (period !== m_reg[1]) begin bad++; $display("FAIL timeout_period got=%0d want=%0d", period, m_reg[1]); end
        total++;
        if (fsm_state !== IDLE) begin bad++; $display("FAIL timeout_state got=%0d want=%0d", fsm_state, IDLE); end
        // Bytes arriving exactly in the expiry cycle must still be taken.
        p = $urandom;
        send_frame(8'h01, p, TO);
        idle(3);
        total++;
        if (period !== m_reg[1]) begin bad++; $display("FAIL timeout_edge got=%h want=%h", period, m_reg[1]); end
        p = $urandom;
        send_frame(8'h02, p, 0);
        idle(3);
        total++;
        if (pulse1 !== m_reg[2]) begin bad++; $display("FAIL timeout_next got=%h want=%h", pulse1, m_reg[2]); end
        total++;
        if (ferr_cnt !== exp_ferr || upd_cnt !== exp_upd) begin
            bad++; $display("FAIL timeout_counts got=%0d/%0d want=%0d/%0d", ferr_cnt, upd_cnt, exp_ferr, exp_upd);
        end
        drain(ok);
        total++;
        if (!ok) begin bad++; $display("FAIL timeout_drain got=%0d want=0 pending", exp_q.size()); end
    endtask

    task automatic test_badcmd();
        bit ok;
        send_frame(8'h09, 32'h4433_2211, 0);
        idle(3);
        for (int i = 0; i < 9; i++) begin
            total++;
            if (act(i) !== m_reg[i]) begin bad++; $display("FAIL badcmd_reg%0d got=%h want=%h", i, act(i), m_reg[i]); end
        end
        total++;
        if (ferr_cnt !== exp_ferr || upd_cnt !== exp_upd) begin
            bad++; $display("FAIL badcmd_counts got=%0d/%0d want=%0d/%0d", ferr_cnt, upd_cnt, exp_ferr, exp_upd);
        end
        drain(ok);
        total++;
        if (!ok) begin bad++; $display("FAIL badcmd_drain got=%0d want=0 pending", exp_q.size()); end
    endtask

    task automatic test_back_to_back();
        bit ok;
        bus.tx_ready = 1'b0;
        hold_mode = 1'b1;
        send_frame(8'h06, 32'h0000_003F, 0);
        send_frame(8'h05, 32'h0000_0007, 0);
        idle(3);
        total++;
        if (att !== 6'd63 || cpmg !== 8'd7) begin bad++; $display("FAIL b2b_regs got=%0d/%0d want=63/7", att, cpmg); end
        total++;
        if (bus.tx_valid !== 1'b1 || bus.tx_data !== exp_q[0]) begin
            bad++; $display("FAIL b2b_overwrite got=%b/%h want=1/%h", bus.tx_valid, bus.tx_data, exp_q[0]);
        end
        idle(5);
        total++;
        if (bus.tx_valid !== 1'b1) begin bad++; $display("FAIL b2b_hold got=%b want=1", bus.tx_valid); end
        hold_mode = 1'b0;
        bus.tx_ready = 1'b1;
        drain(ok);
        total++;
        if (!ok) begin bad++; $display("FAIL b2b_drain got=%0d want=0 pending", exp_q.size()); end
        for (int k = 0; k < 4; k++) send_frame(8'($urandom_range(0, 8)), $urandom, 0);
        idle(3);
        for (int i = 0; i < 9; i++) begin
            total++;
            if (act(i) !== m_reg[i]) begin bad++; $display("FAIL b2b_reg%0d got=%h want=%h", i, act(i), m_reg[i]); end
        end
        drain(ok);
        total++;
        if (!ok || upd_cnt !== exp_upd) begin bad++; $display("FAIL b2b_burst got=%0d upd want=%0d", upd_cnt, exp_upd); end
    endtask

    task automatic test_reset_midframe();
        bit ok;
        bus.tx_ready = 1'b0;
        send_frame(8'h02, 32'h1234_5678, 0);
        idle(3);
        send_byte(8'h07); send_byte(8'hEF); send_byte(8'hBE);
        resetn = 1'b0;
        #2;
        model_reset();
        for (int i = 0; i < 9; i++) begin
            total++;
            if (act(i) !== m_reg[i]) begin bad++; $display("FAIL rstmid_reg%0d got=%h want=%h", i, act(i), m_reg[i]); end
        end
        total++;
        if (bus.tx_valid !== 1'b0 || fsm_state !== IDLE) begin
            bad++; $display("FAIL rstmid_ack_state got=%b/%0d want=0/%0d", bus.tx_valid, fsm_state, IDLE);
        end
        bus.tx_ready = 1'b1;
        idle(2);
        resetn = 1'b1;
        idle(2);
        send_frame(8'h08, 32'h0000_0010, 0);
        idle(3);
        total++;
        if (nut_d !== 32'd16 || nut_w !== 32'd0) begin bad++; $display("FAIL rstmid_nutd got=%0d/%0d want=16/0", nut_d, nut_w); end
        drain(ok);
        total++;
        if (!ok) begin bad++; $display("FAIL rstmid_drain got=%0d want=0 pending", exp_q.size()); end
    endtask

    task automatic test_random();
        bit ok;
        for (int n = 0; n < 40; n++) begin
            send_frame(8'($urandom_range(0, 11)), $urandom, $urandom_range(0, 2));
            idle(3);
            for (int i = 0; i < 9; i++) begin
                total++;
                if (act(i) !== m_reg[i]) begin bad++; $display("FAIL rand%0d_reg%0d got=%h want=%h", n, i, act(i), m_reg[i]); end
            end
        end
        drain(ok);
        total++;
        if (!ok || upd_cnt !== exp_upd || ferr_cnt !== exp_ferr) begin
            bad++; $display("FAIL rand_counts got=%0d/%0d want=%0d/%0d", upd_cnt, ferr_cnt, exp_upd, exp_ferr);
        end
    endtask

    initial begin
        bus.rx_data  = 8'h00;
        bus.rx_valid = 1'b0;
        bus.tx_ready = 1'b1;
        #2;
        test_reset();
        test_delay();
        test_toggle();
        test_timeout();
        test_badcmd();
        test_back_to_back();
        test_reset_midframe();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
